// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_mem_controller_pkg;

  localparam int unsigned SRAM_AW          = 18;
  localparam int unsigned SRAM_DW          = 16;
  localparam int unsigned SRAM_HALF_CYCLES = 3;
  localparam logic [31:0] SRAM_BASE_ADDR   = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_e;

  // Word index inside the SRAM for a processor byte address; wraps by truncation.
  function automatic logic [SRAM_AW-2:0] sram_word_index(input logic [31:0] byte_addr,
                                                         input logic [31:0] base_addr);
    logic [31:0] eff;
    eff = byte_addr - base_addr;
    return eff[SRAM_AW:2];
  endfunction

endpackage

// File: rtl/sram_mem_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit accesses on an async SRAM.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = SRAM_HALF_CYCLES,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam logic [3:0] CNT_LAST = 4'(HALF_CYCLES - 1);

  sram_state_e        state_q;
  logic [3:0]         cnt_q;
  logic               op_wr_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [SRAM_DW-1:0] sram_dq_out_q;
  logic               sram_dq_oe_q;
  logic               sram_we_n_q;

  // Transfer sequencer: pad outputs are registered one cycle ahead of the phase they serve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rd_en || wr_en) begin
            // Simultaneous rd_en/wr_en resolves to a write.
            state_q       <= LOW;
            cnt_q         <= '0;
            op_wr_q       <= wr_en;
            word_q        <= sram_word_index(address, BASE_ADDR);
            wdata_q       <= write_data;
            sram_addr_q   <= {sram_word_index(address, BASE_ADDR), 1'b0};
            sram_dq_out_q <= write_data[15:0];
            sram_dq_oe_q  <= wr_en;
            sram_we_n_q   <= ~wr_en;
          end
        end
        LOW: begin
          if (cnt_q == CNT_LAST) begin
            state_q       <= HIGH;
            cnt_q         <= '0;
            sram_addr_q   <= {word_q, 1'b1};
            sram_dq_out_q <= wdata_q[31:16];
            if (!op_wr_q) read_data_q[15:0] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HIGH: begin
          if (cnt_q == CNT_LAST) begin
            state_q      <= DONE;
            cnt_q        <= '0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            if (!op_wr_q) read_data_q[31:16] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pipeline may advance when idle with no request, or in the single DONE cycle.
  always_comb begin
    ready = ((state_q == IDLE) && !rd_en && !wr_en) || (state_q == DONE);
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_ce_n   = 1'b0;
  assign sram_oe_n   = 1'b0;
  assign sram_ub_n   = 1'b0;
  assign sram_lb_n   = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized self-checking bench for sram_mem_controller against a word-level memory model.
module tb_sram_mem_controller;

  localparam int unsigned H = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // ---------------- DUT A: default HALF_CYCLES ----------------
  logic        rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

  sram_mem_controller dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  bit [15:0] sram_a [0:262143];
  always @(posedge clk) if (!sram_we_n) sram_a[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram_a[sram_addr];

  // ---------------- DUT B: HALF_CYCLES = 1 ----------------
  logic        b_rst, b_rd_en, b_wr_en;
  logic [31:0] b_address, b_write_data, b_read_data;
  logic        b_ready;
  logic [17:0] b_sram_addr;
  logic [15:0] b_sram_dq_out, b_sram_dq_in;
  logic        b_sram_dq_oe, b_sram_we_n, b_sram_ce_n, b_sram_oe_n, b_sram_ub_n, b_sram_lb_n;

  sram_mem_controller #(.HALF_CYCLES(1)) dut_b (
    .clk(clk), .rst(b_rst), .rd_en(b_rd_en), .wr_en(b_wr_en),
    .address(b_address), .write_data(b_write_data), .read_data(b_read_data), .ready(b_ready),
    .sram_addr(b_sram_addr), .sram_dq_out(b_sram_dq_out), .sram_dq_in(b_sram_dq_in),
    .sram_dq_oe(b_sram_dq_oe), .sram_we_n(b_sram_we_n), .sram_ce_n(b_sram_ce_n),
    .sram_oe_n(b_sram_oe_n), .sram_ub_n(b_sram_ub_n), .sram_lb_n(b_sram_lb_n)
  );

  bit [15:0] sram_b [0:262143];
  always @(posedge clk) if (!b_sram_we_n) sram_b[b_sram_addr] <= b_sram_dq_out;
  assign b_sram_dq_in = sram_b[b_sram_addr];

  // ---------------- Reference model ----------------
  logic [31:0] model_mem [int unsigned];
  logic [31:0] last_rd;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return 17'((off >> 2) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] model_read(input logic [16:0] idx);
    if (model_mem.exists(int'(idx))) return model_mem[int'(idx)];
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Caller is at posedge+1 of the cycle in which the request is presented (cycle 0).
  // Returns at posedge+1 of the IDLE cycle that follows DONE, with the request still driven.
  task automatic run_access(input bit wr, input bit both, input logic [31:0] addr,
                            input logic [31:0] wd, input bit scramble);
    logic [16:0] idx;
    bit          hi;
    idx        = word_of(addr);
    wr_en      = wr;
    rd_en      = !wr || both;
    address    = addr;
    write_data = wd;
    if (wr) model_mem[int'(idx)] = wd;
    else    last_rd = model_read(idx);
    for (int k = 0; k <= 2*H+1; k++) begin
      @(negedge clk);
      check("ready", 32'(ready), 32'(k == 2*H+1));
      if (k >= 1 && k <= 2*H) begin
        hi = (k > H);
        check("sram_addr", 32'(sram_addr), 32'({idx, hi}));
        check("we_n", 32'(sram_we_n), 32'(!wr));
        check("dq_oe", 32'(sram_dq_oe), 32'(wr));
        if (wr) check("dq_out", 32'(sram_dq_out), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
      end
      if (k == 2*H+1) begin
        check("we_n_done", 32'(sram_we_n), 32'd1);
        check("read_data", read_data, last_rd);
      end
      @(posedge clk); #1;
      if (scramble && k < 2*H+1) begin
        address    = $urandom;
        write_data = $urandom;
      end
    end
  endtask

  task automatic idle_cycle();
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, d;
    bit          w;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    b_rst = 1'b1; b_rd_en = 1'b0; b_wr_en = 1'b0; b_address = '0; b_write_data = '0;
    last_rd = '0;
    sram_b[18'd8] = 16'h5678;
    sram_b[18'd9] = 16'h1234;
    #1;
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; b_rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_oe", 32'(sram_dq_oe), 32'd0);
      check("idle_rd", read_data, 32'd0);
      check("const_pins", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'd0);
    end
    @(posedge clk); #1;

    // Directed write then read back
    run_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
    idle_cycle();
    run_access(1'b0, 1'b0, 32'd1032, 32'h0, 1'b0);
    idle_cycle();
    check("readback", read_data, 32'hDEADBEEF);

    // Back-to-back store then load with requests held
    run_access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 1'b0);
    run_access(1'b0, 1'b0, 32'd1040, 32'h0, 1'b0);
    idle_cycle();

    // Below base wraps to the top word; aliasing above the 512 KiB window
    run_access(1'b1, 1'b0, 32'd1020, 32'hA5A5_5A5A, 1'b0);
    idle_cycle();
    run_access(1'b0, 1'b0, 32'd1020, 32'h0, 1'b0);
    idle_cycle();
    run_access(1'b1, 1'b0, 32'd1024 + 32'h0008_0004, 32'h0BAD_CAFE, 1'b0);
    idle_cycle();
    run_access(1'b0, 1'b0, 32'd1028, 32'h0, 1'b0);
    idle_cycle();

    // Randomized traffic, including rd+wr together and mid-transfer input changes
    for (int i = 0; i < 40; i++) begin
      a = 32'd1024 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) a = a + 32'h0008_0000;
      d = $urandom;
      w = ($urandom_range(0, 1) == 1);
      run_access(w, w && ($urandom_range(0, 3) == 0), a, d, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Reset during HIGH phase of a write (word 200 is never read afterwards)
    wr_en = 1'b1; address = 32'd1024 + 32'd800; write_data = 32'h1111_2222;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_rd", read_data, 32'd0);
    last_rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_access(1'b0, 1'b0, 32'd1032, 32'h0, 1'b0);
    idle_cycle();

    // HALF_CYCLES=1 instance: read returns in cycle 3
    b_rd_en = 1'b1; b_address = 32'd1024 + 32'd16;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check("b_ready", 32'(b_ready), 32'(k == 3));
      check("b_we_n", 32'(b_sram_we_n), 32'd1);
      if (k == 3) check("b_read_data", b_read_data, 32'h12345678);
      @(posedge clk); #1;
    end
    b_rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences MEM-stage data accesses (mem_read/mem_write from the decoder, carried down the pipeline) onto an external 16-bit asynchronous SRAM.
- Each 32-bit word transfer is split into two 16-bit half accesses: low half first, then high half.
- While a transfer is in progress, ready is deasserted; the top level uses ~ready to freeze every pipeline register and the PC.

Parameters:
- HALF_CYCLES, 3, clock cycles each 16-bit half access occupies the SRAM bus (legal range 1..15).
- BASE_ADDR, 1024, processor byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  MEM-stage load request; held until ready.
- wr_en  in  1  MEM-stage store request; held until ready.
- address  in  32  byte address, from the ALU result.
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result; registered.
- ready  out  1  1 = no transfer pending, pipeline may advance.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_out  out  16  data driven to the SRAM.
- sram_dq_in  in  16  data read from the SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the pad.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  constant 0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, cnt=0, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Address map:
  - eff = address - BASE_ADDR, 32-bit modulo arithmetic.
  - sram_addr = {eff[18:2], half}, where half=0 for the low phase and 1 for the high phase.
  - eff[1:0] is ignored; word-aligned accesses only.
  - No range check; out-of-range addresses wrap by truncation.
- States: IDLE, LOW, HIGH, DONE. A 4-bit phase counter cnt runs within each phase.
- IDLE:
  - rd_en or wr_en sampled high: go to LOW, cnt=0, latch op (write if wr_en, else read), address and write_data.
  - rd_en and wr_en both high: illegal; the transfer is treated as a write.
- LOW: after HALF_CYCLES cycles (cnt == HALF_CYCLES-1), go to HIGH with cnt=0.
- HIGH: after HALF_CYCLES cycles, go to DONE.
- DONE: one cycle only, then return to IDLE unconditionally.
- A request still present in that IDLE cycle is a new access and starts a fresh transfer.
- ready (combinational) = (state==IDLE and !rd_en and !wr_en) or state==DONE.
- Latency: request presented in IDLE at cycle 0 gives ready=0 for cycles 0..2*HALF_CYCLES and ready=1 at cycle 2*HALF_CYCLES+1 (DONE). With default HALF_CYCLES=3, ready rises in cycle 7.
- Write phases (LOW/HIGH with op=write), all cycles:
  - sram_we_n=0 and sram_dq_oe=1.
  - sram_dq_out = latched write_data[15:0] in LOW, [31:16] in HIGH.
  - sram_we_n returns to 1 in DONE/IDLE.
- Read phases:
  - sram_we_n=1 and sram_dq_oe=0.
  - On the last cycle of LOW, sram_dq_in is captured into read_data[15:0].
  - On the last cycle of HIGH, sram_dq_in is captured into read_data[31:16].
  - read_data holds until the next read completes; writes never modify it.
- sram_addr, sram_dq_out, sram_we_n and sram_dq_oe are registered, so they are glitch-free to the pads.
- Inputs are latched at transfer start; changes to address or write_data mid-transfer are ignored.
- Reset mid-transfer aborts it immediately. A partial SRAM write is acceptable; the next access restarts from IDLE.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, LOW=2'd1, HIGH=2'd2, DONE=2'd3);
  - default constants SRAM_BASE_ADDR=1024, SRAM_HALF_CYCLES=3;
  - SRAM address width 18 and data width 16.
- No sub-module; the phase counter and FSM stay in one module.
- Pad tristate (inout) is resolved at the top level using sram_dq_oe.

Test Plan:
- Reset idle: rst pulse, no request -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0, and these hold across 10 idle cycles.
- Write: wr_en=1, address=1024+8, write_data=32'hDEADBEEF.
  - Cycles 1..3: sram_addr=18'h4, sram_dq_out=16'hBEEF, we_n=0.
  - Cycles 4..6: sram_addr=18'h5, sram_dq_out=16'hDEAD, we_n=0.
  - Cycle 7: ready=1, we_n=1.
- Read back: SRAM model returns the values stored at 18'h4/5; rd_en=1, address=1032 -> ready rises in cycle 7 with read_data=32'hDEADBEEF; no we_n pulse occurs.
- Back-to-back: store then load held continuously -> two full 8-cycle windows, ready=1 exactly in cycles 7 and 15, and the second transfer starts in the IDLE cycle after DONE.
- Reset mid-transfer: assert rst during HIGH of a write -> immediately state=IDLE, we_n=1, dq_oe=0; after release a new read completes in 8 cycles.
- HALF_CYCLES=1 instance: read of 32'h12345678 -> ready=0 for cycles 0..2, ready=1 in cycle 3, read_data=32'h12345678.
